// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch
// Description : Instruction memory with a registered, handshaked fetch port.
//               A request (valid/ready) carrying a byte address is accepted,
//               optionally delayed by WAITSTATES cycles, and answered on a
//               valid/ready response channel with the instruction and the
//               address it came from. FLUSH discards any in-flight or held
//               fetch (redirect).
// Macro       : IMEM_ALIGN_CHECK_EN - when defined, misaligned fetches answer
//               with RESP_FAULT=1 and RESP_INSTR=NOP_INSTR without reading
//               the memory. Undefined: RESP_FAULT is 0 and the low address
//               bits are ignored for the word index.
// Ports       : CLK, RESET (sync, active-high)
//               REQ_VALID/REQ_READY/REQ_ADDR      - fetch request channel
//               FLUSH                             - kill in-flight fetches
//               RESP_VALID/RESP_READY/RESP_INSTR/
//               RESP_ADDR/RESP_FAULT              - fetch response channel
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch #(
    parameter string             INITFILE   = "Test2.mif",
    parameter int                DBITS      = 32,
    parameter int                ADDRBITS   = 13,
    parameter int                WORDBITS   = 2,
    parameter int                MEMWORDS   = 2048,
    parameter int                WAITSTATES = 0,
    parameter logic [DBITS-1:0]  NOP_INSTR  = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic [ADDRBITS-1:0] REQ_ADDR,
    input  logic                FLUSH,
    output logic                RESP_VALID,
    input  logic                RESP_READY,
    output logic [DBITS-1:0]    RESP_INSTR,
    output logic [ADDRBITS-1:0] RESP_ADDR,
    output logic                RESP_FAULT
);

    localparam int         c_IDXBITS  = ADDRBITS - WORDBITS;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;
    localparam logic [3:0] c_WS_LOAD  = (WAITSTATES > 0) ? 4'(WAITSTATES - 1) : 4'd0;

`ifdef IMEM_ALIGN_CHECK_EN
    localparam logic       c_ALIGN_CHECK = 1'b1;
`else
    localparam logic       c_ALIGN_CHECK = 1'b0;
`endif

    // Reject configurations the index arithmetic cannot support.
    generate
        if ((MEMWORDS != (1 << c_IDXBITS)) || (WAITSTATES < 0) || (WAITSTATES > 15) ||
            (WORDBITS < 1) || (INITFILE == "")) begin : g_cfg_error
            $error("imem_fetch: illegal parameter combination");
        end
    endgenerate

    (* ram_init_file = INITFILE *) logic [DBITS-1:0] r_mem [0:MEMWORDS-1];

    logic [1:0]           r_state_q, w_state_d;
    logic [3:0]           r_cnt_q,   w_cnt_d;
    logic [ADDRBITS-1:0]  r_addr_q,  w_addr_d;
    logic                 r_fault_q, w_fault_d;
    logic [DBITS-1:0]     r_instr_q;

    logic                 w_accept;
    logic                 w_req_misalign;
    logic                 w_rd_en;
    logic                 w_rd_nop;
    logic [c_IDXBITS-1:0] w_rd_idx;

    // Ready is a function of RESP_READY: a held response that is being taken
    // frees the slot for a back-to-back request in the same cycle.
    assign REQ_READY = ~FLUSH & ~RESET &
                       ((r_state_q == c_ST_IDLE) | ((r_state_q == c_ST_RESP) & RESP_READY));
    assign w_accept  = REQ_VALID & REQ_READY;

    assign w_req_misalign = c_ALIGN_CHECK & (|REQ_ADDR[WORDBITS-1:0]);

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_addr_d  = r_addr_q;
        w_fault_d = r_fault_q;
        w_rd_en   = 1'b0;
        w_rd_idx  = r_addr_q[ADDRBITS-1:WORDBITS];
        w_rd_nop  = r_fault_q;

        if (w_accept) begin
            // Accept is only possible from IDLE or from a RESP being taken.
            w_addr_d  = REQ_ADDR;
            w_fault_d = w_req_misalign;
            if (WAITSTATES > 0) begin
                w_state_d = c_ST_WAIT;
                w_cnt_d   = c_WS_LOAD;
            end else begin
                w_state_d = c_ST_RESP;
                w_rd_en   = 1'b1;
                w_rd_idx  = REQ_ADDR[ADDRBITS-1:WORDBITS];
                w_rd_nop  = w_req_misalign;
            end
        end else begin
            case (r_state_q)
                c_ST_WAIT: begin
                    if (r_cnt_q == 4'd0) begin
                        w_rd_en   = 1'b1;
                        w_state_d = c_ST_RESP;
                    end else begin
                        w_cnt_d = r_cnt_q - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    if (RESP_READY) begin
                        w_state_d = c_ST_IDLE;
                    end
                end
                default: w_state_d = c_ST_IDLE;
            endcase
        end

        // A response shown alongside FLUSH counts as not taken; the fetch dies.
        if (FLUSH) begin
            w_state_d = c_ST_IDLE;
            w_cnt_d   = 4'd0;
            w_rd_en   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q <= c_ST_IDLE;
            r_cnt_q   <= 4'd0;
            r_addr_q  <= '0;
            r_fault_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_addr_q  <= w_addr_d;
            r_fault_q <= w_fault_d;
        end
    end

    // Synchronous read port; a faulting fetch substitutes NOP_INSTR for the word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_instr_q <= '0;
        end else if (w_rd_en) begin
            r_instr_q <= w_rd_nop ? NOP_INSTR : r_mem[w_rd_idx];
        end
    end

    assign RESP_VALID = (r_state_q == c_ST_RESP);
    assign RESP_INSTR = r_instr_q;
    assign RESP_ADDR  = r_addr_q;
    assign RESP_FAULT = r_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch
// Description : Self-checking bench for imem_fetch. Two instances share the
//               clock: dut0 (WAITSTATES=0) and dut2 (WAITSTATES=2).
//               Directed table rows, hand-written wait-state/flush sequences,
//               then random traffic compared against a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int NW = 2048;

`ifdef IMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        [2];
    logic          req_valid  [2];
    logic          req_ready  [2];
    logic [AW-1:0] req_addr   [2];
    logic          flush      [2];
    logic          resp_valid [2];
    logic          resp_ready [2];
    logic [DW-1:0] resp_instr [2];
    logic [AW-1:0] resp_addr  [2];
    logic          resp_fault [2];

    logic [DW-1:0] mem [NW];

    int n_chk = 0;
    int n_err = 0;

    imem_fetch #(.WAITSTATES(0)) dut0 (
        .CLK(clk), .RESET(rst[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .REQ_ADDR(req_addr[0]), .FLUSH(flush[0]), .RESP_VALID(resp_valid[0]),
        .RESP_READY(resp_ready[0]), .RESP_INSTR(resp_instr[0]), .RESP_ADDR(resp_addr[0]),
        .RESP_FAULT(resp_fault[0])
    );

    imem_fetch #(.WAITSTATES(2)) dut2 (
        .CLK(clk), .RESET(rst[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .REQ_ADDR(req_addr[1]), .FLUSH(flush[1]), .RESP_VALID(resp_valid[1]),
        .RESP_READY(resp_ready[1]), .RESP_INSTR(resp_instr[1]), .RESP_ADDR(resp_addr[1]),
        .RESP_FAULT(resp_fault[1])
    );

    typedef struct {
        logic          rst, v;
        logic [AW-1:0] a;
        logic          fl, rr;
        logic          e_rdy, e_rv, chk_d;
        logic [DW-1:0] e_instr;
        logic [AW-1:0] e_addr;
        logic          e_fault;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, v, input logic [AW-1:0] a, input logic fl, rr,
                       input logic e_rdy, e_rv, chk_d, input logic [DW-1:0] e_instr,
                       input logic [AW-1:0] e_addr, input logic e_fault);
        vec_t t;
        t.rst = r; t.v = v; t.a = a; t.fl = fl; t.rr = rr;
        t.e_rdy = e_rdy; t.e_rv = e_rv; t.chk_d = chk_d;
        t.e_instr = e_instr; t.e_addr = e_addr; t.e_fault = e_fault;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic r, v, input logic [AW-1:0] a,
                         input logic fl, rr);
        rst[k] = r; req_valid[k] = v; req_addr[k] = a; flush[k] = fl; resp_ready[k] = rr;
    endtask

    // Apply inputs just after the falling edge and let them settle.
    task automatic cyc(input int k, input logic r, v, input logic [AW-1:0] a,
                       input logic fl, rr);
        @(negedge clk);
        drive(k, r, v, a, fl, rr);
        #1;
    endtask

    task automatic chk_hs(input int k, input string tag, input logic e_rdy, e_rv);
        check({tag, ".req_ready"},  {31'd0, req_ready[k]},  {31'd0, e_rdy});
        check({tag, ".resp_valid"}, {31'd0, resp_valid[k]}, {31'd0, e_rv});
    endtask

    task automatic chk_data(input int k, input string tag, input logic [DW-1:0] instr,
                            input logic [AW-1:0] addr, input logic fault);
        check({tag, ".resp_instr"}, resp_instr[k], instr);
        check({tag, ".resp_addr"},  {19'd0, resp_addr[k]}, {19'd0, addr});
        check({tag, ".resp_fault"}, {31'd0, resp_fault[k]}, {31'd0, fault});
    endtask

    function automatic logic [DW-1:0] exp_instr(input logic [AW-1:0] a);
        if (ALIGN && (a[1:0] != 2'b00)) return 32'h0;
        return mem[a[AW-1:2]];
    endfunction

    // Random-phase model state: one outstanding fetch per instance, tracked by
    // the cycle at which its response becomes visible.
    bit            m_busy [2];
    int            m_due  [2];
    logic [AW-1:0] m_addr [2];

    initial begin
        for (int k = 0; k < 2; k++) drive(k, 1'b1, 1'b1, 13'h00C, 1'b0, 1'b0);

        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;
        mem[3] = 32'hDEAD_BEEF; mem[4] = 32'h4444_4444; mem[8] = 32'h8888_8888;
        mem[NW-1] = 32'hCAFE_F00D;
        for (int i = 0; i < NW; i++) begin
            dut0.r_mem[i] = mem[i];
            dut2.r_mem[i] = mem[i];
        end

        // ---------------- directed table on dut0 (WAITSTATES=0) ----------------
        add(1, 1, 13'h00C, 0, 0,  0, 0, 1, 32'h0,    13'h000, 0);
        add(1, 1, 13'h00C, 0, 0,  0, 0, 1, 32'h0,    13'h000, 0);
        add(0, 1, 13'h00C, 0, 1,  1, 0, 1, 32'h0,    13'h000, 0);
        add(0, 1, 13'h000, 0, 1,  1, 1, 1, mem[3],   13'h00C, 0);
        add(0, 1, 13'h004, 0, 1,  1, 1, 1, mem[0],   13'h000, 0);
        add(0, 1, 13'h008, 0, 1,  1, 1, 1, mem[1],   13'h004, 0);
        add(0, 1, 13'h00C, 0, 1,  1, 1, 1, mem[2],   13'h008, 0);
        add(0, 0, 13'h000, 0, 0,  0, 1, 1, mem[3],   13'h00C, 0);
        add(0, 1, 13'h1FFC, 0, 0, 0, 1, 1, mem[3],   13'h00C, 0);
        add(0, 0, 13'h000, 0, 1,  1, 1, 1, mem[3],   13'h00C, 0);
        add(0, 1, 13'h1FFC, 0, 1, 1, 0, 0, 32'h0,    13'h000, 0);
        add(0, 0, 13'h000, 1, 0,  0, 1, 1, mem[NW-1], 13'h1FFC, 0);
        add(0, 1, 13'h008, 0, 1,  1, 0, 0, 32'h0,    13'h000, 0);
        add(0, 0, 13'h000, 1, 1,  0, 1, 1, mem[2],   13'h008, 0);
        add(0, 1, 13'h006, 0, 1,  1, 0, 0, 32'h0,    13'h000, 0);
        add(0, 0, 13'h000, 0, 1,  1, 1, 1, ALIGN ? 32'h0 : mem[1], 13'h006, ALIGN);
        add(0, 1, 13'h00C, 1, 1,  0, 0, 0, 32'h0,    13'h000, 0);
        add(0, 0, 13'h000, 0, 0,  1, 0, 0, 32'h0,    13'h000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("tbl[%0d]", i);
            cyc(0, tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].fl, tbl[i].rr);
            chk_hs(0, tag, tbl[i].e_rdy, tbl[i].e_rv);
            if (tbl[i].chk_d) chk_data(0, tag, tbl[i].e_instr, tbl[i].e_addr, tbl[i].e_fault);
        end

        // ---------------- wait states + stall on dut2 (WAITSTATES=2) ----------------
        cyc(1, 0, 1, 13'h010, 0, 0);
        chk_hs(1, "ws_accept", 1, 0);
        for (int c = 1; c <= 6; c++) begin
            string tag;
            tag = $sformatf("ws_c%0d", c);
            cyc(1, 0, 0, 13'h000, 0, (c == 5));
            if (c <= 2) begin
                chk_hs(1, tag, 0, 0);
            end else if (c <= 4) begin
                chk_hs(1, tag, 0, 1);
                chk_data(1, tag, mem[4], 13'h010, 0);
            end else if (c == 5) begin
                chk_hs(1, tag, 1, 1);
                chk_data(1, tag, mem[4], 13'h010, 0);
            end else begin
                chk_hs(1, tag, 1, 0);
            end
        end

        // ---------------- flush during WAIT on dut2 ----------------
        cyc(1, 0, 1, 13'h010, 0, 1);
        chk_hs(1, "fl_accept", 1, 0);
        cyc(1, 0, 0, 13'h000, 1, 1);
        chk_hs(1, "fl_during", 0, 0);
        cyc(1, 0, 0, 13'h000, 0, 1);
        chk_hs(1, "fl_after", 1, 0);
        for (int c = 0; c < 4; c++) begin
            cyc(1, 0, 0, 13'h000, 0, 1);
            chk_hs(1, $sformatf("fl_quiet%0d", c), 1, 0);
        end
        cyc(1, 0, 1, 13'h020, 0, 1);
        chk_hs(1, "fl_next_accept", 1, 0);
        cyc(1, 0, 0, 13'h000, 0, 1);
        chk_hs(1, "fl_next_w1", 0, 0);
        cyc(1, 0, 0, 13'h000, 0, 1);
        chk_hs(1, "fl_next_w2", 0, 0);
        cyc(1, 0, 0, 13'h000, 0, 1);
        chk_hs(1, "fl_next_resp", 1, 1);
        chk_data(1, "fl_next_resp", mem[8], 13'h020, 0);
        cyc(1, 0, 0, 13'h000, 0, 0);
        chk_hs(1, "fl_next_done", 1, 0);

        // ---------------- random traffic on both instances ----------------
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_due[k]  = 0;
            m_addr[k] = '0;
        end
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                drive(k, ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
                      AW'($urandom), ($urandom_range(0, 14) == 0), ($urandom_range(0, 9) < 6));
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                int   ws;
                logic e_rv, e_rdy;
                string tag;
                ws    = (k == 0) ? 0 : 2;
                tag   = $sformatf("rnd%0d[%0d]", ws, t);
                e_rv  = m_busy[k] && (t >= m_due[k]);
                e_rdy = !flush[k] && !rst[k] && (!m_busy[k] || (e_rv && resp_ready[k]));
                chk_hs(k, tag, e_rdy, e_rv);
                if (e_rv) chk_data(k, tag, exp_instr(m_addr[k]), m_addr[k],
                                   ALIGN && (m_addr[k][1:0] != 2'b00));
                if (rst[k] || flush[k]) begin
                    m_busy[k] = 1'b0;
                end else if (req_valid[k] && e_rdy) begin
                    m_busy[k] = 1'b1;
                    m_due[k]  = t + 1 + ws;
                    m_addr[k] = req_addr[k];
                end else if (e_rv && resp_ready[k]) begin
                    m_busy[k] = 1'b0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
